bit_serial_subtractor: RTL

- Sequential subtractor that computes `a - b - borrow_in` for two `WIDTH`-bit operands, one bit per clock, LSB first.
- Built around a single full-subtractor cell and a registered borrow.
- Sits in the arithmetic library next to the combinational adder cells. It trades latency for area when operands arrive infrequently.
- Uses a start/busy/done handshake, so a controller FSM or testbench can drive it directly.

---
 rtl/bit_serial_subtractor_if.sv | 25 ++
 rtl/bit_serial_subtractor.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/bit_serial_subtractor_if.sv
// Start/busy/done handshake bundle for the bit-serial subtractor.
// The master drives the request and operands; the slave returns status and results.
interface bit_serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  modport master (
    output start, a, b, borrow_in,
    input  busy, done, diff, borrow_out, overflow
  );

  modport slave (
    input  start, a, b, borrow_in,
    output busy, done, diff, borrow_out, overflow
  );
endinterface

// File: rtl/bit_serial_subtractor.sv
// Bit-serial a - b - borrow_in, one bit per clock, LSB first, built around a
// single full-subtractor cell with a registered borrow.
module bit_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  bit_serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic fs_diff(input logic x, input logic y, input logic bi);
    return x ^ y ^ bi;
  endfunction

  function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
    return (~x & y) | (~(x ^ y) & bi);
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [WIDTH-1:0] res_r;
  logic             br_r;
  logic             a_msb_r;
  logic             b_msb_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;
  logic             borrow_out_r;
  logic             overflow_r;
  logic             d_s;
  logic             br_next_s;
  logic             load_s;
  logic             shift_s;
  logic             last_s;

  assign d_s       = fs_diff(sa_r[0], sb_r[0], br_r);
  assign br_next_s = fs_borrow(sa_r[0], sb_r[0], br_r);

  // Next-state and datapath control decode.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    shift_s = 1'b0;
    last_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          load_s  = 1'b1;
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        shift_s = 1'b1;
        if (cnt_r == CNT_LAST) begin
          last_s  = 1'b1;
          state_s = ST_DONE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == ST_SHIFT);
      done_r  <= (state_s == ST_DONE);
    end
  end

  // Operand capture, serial shifting and result/borrow accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_r    <= {WIDTH{1'b0}};
      sb_r    <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      br_r    <= 1'b0;
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else if (load_s) begin
      sa_r    <= bus.a;
      sb_r    <= bus.b;
      br_r    <= bus.borrow_in;
      a_msb_r <= bus.a[WIDTH-1];
      b_msb_r <= bus.b[WIDTH-1];
      cnt_r   <= {CW{1'b0}};
    end else if (shift_s) begin
      sa_r  <= {1'b0, sa_r[WIDTH-1:1]};
      sb_r  <= {1'b0, sb_r[WIDTH-1:1]};
      res_r <= {d_s, res_r[WIDTH-1:1]};
      br_r  <= br_next_s;
      // Saturate on the last bit so the counter never wraps.
      cnt_r <= last_s ? cnt_r : (cnt_r + CNT_ONE);
    end else begin
      sa_r  <= sa_r;
      sb_r  <= sb_r;
      res_r <= res_r;
      br_r  <= br_r;
      cnt_r <= cnt_r;
    end
  end

  // Final borrow and signed overflow latched as the last bit is produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      borrow_out_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else if (last_s) begin
      borrow_out_r <= br_next_s;
      overflow_r   <= (a_msb_r != b_msb_r) && (d_s != a_msb_r);
    end else begin
      borrow_out_r <= borrow_out_r;
      overflow_r   <= overflow_r;
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.diff       = res_r;
  assign bus.borrow_out = borrow_out_r;
  assign bus.overflow   = overflow_r;

endmodule
